// File: rtl/mmr_bank_pkg.sv
// Shared definitions for the memory-mapped register bank:
// the register access modes and a helper that picks one mode out of the packed MODES vector.
package mmr_bank_pkg;

  typedef enum logic [1:0] {
    MMR_RW    = 2'd0,
    MMR_RO    = 2'd1,
    MMR_W1C   = 2'd2,
    MMR_PULSE = 2'd3
  } mmr_mode_e;

  localparam int MMR_MAX_COUNT = 32;

  // The packed mode vector is widened to the maximum register count
  // so that this single helper can serve every bank size.
  function automatic mmr_mode_e mode_at(input logic [2*MMR_MAX_COUNT-1:0] modes, input int idx);
    return mmr_mode_e'(modes[2*idx +: 2]);
  endfunction

endpackage

// File: rtl/mmr_bank_cell.sv
// One register of the bank: it holds the stored value and the mode-specific next-state logic,
// and it produces the access strobes for that register.
module mmr_bank_cell
  import mmr_bank_pkg::*;
#(
  parameter int        W         = 32,
  parameter mmr_mode_e MODE      = MMR_RW,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         bus_we,
  input  logic         bus_re,
  input  logic [W-1:0] bus_wdata,
  input  logic         hw_we,
  input  logic [W-1:0] hw_val,
  input  logic [W-1:0] hw_set,
  output logic [W-1:0] val,
  output logic [W-1:0] w1c_bits,
  output logic         wr_strobe,
  output logic         rd_strobe
);

  // PULSE registers must come out of reset idle, whatever value DEFAULTS holds.
  localparam logic [W-1:0] INIT = (MODE == MMR_PULSE) ? '0 : RESET_VAL;

  logic [W-1:0] val_q, val_d;
  logic         wr_strobe_q, wr_strobe_d;
  logic         rd_strobe_q, rd_strobe_d;

  always_comb begin
    val_d       = val_q;
    wr_strobe_d = bus_we && (MODE != MMR_RO);
    rd_strobe_d = bus_re;
    case (MODE)
      MMR_RW: begin
        if (bus_we)     val_d = bus_wdata;
        else if (hw_we) val_d = hw_val;
      end
      MMR_RO: begin
        if (hw_we) val_d = hw_val;
      end
      // hw_set is OR-ed in after the clear, so a set wins over a clear of the same bit.
      MMR_W1C: begin
        if (bus_we) val_d = (val_q & ~bus_wdata) | hw_set;
        else        val_d = val_q | hw_set;
      end
      default: begin
        val_d = '0;
        if (bus_we)     val_d = bus_wdata;
        else if (hw_we) val_d = hw_val;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q       <= INIT;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      val_q       <= val_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign val       = val_q;
  assign w1c_bits  = (MODE == MMR_W1C) ? val_q : '0;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;

endmodule

// File: rtl/mmr_bank.sv
// Bank of COUNT memory-mapped registers on the tenyr data bus, each with its own access mode,
// plus the window decode, the tristate read-back path and a registered W1C interrupt.
module mmr_bank
  import mmr_bank_pkg::*;
#(
  parameter int unsigned BASE           = 0,
  parameter int          COUNT          = 4,
  parameter int          BUS_ADDR_WIDTH = 32,
  parameter int          BUS_DATA_WIDTH = 32,
  parameter int          MMR_WIDTH      = BUS_DATA_WIDTH,
  parameter logic [COUNT*2-1:0]         MODES    = '0,
  parameter logic [COUNT-1:0]           RE_MASK  = '1,
  parameter logic [COUNT*MMR_WIDTH-1:0] DEFAULTS = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       rw,
  input  logic [BUS_ADDR_WIDTH-1:0]  addr,
  inout  wire  [BUS_DATA_WIDTH-1:0]  data,
  input  logic [COUNT-1:0]           hw_we,
  input  logic [COUNT*MMR_WIDTH-1:0] hw_val,
  input  logic [COUNT*MMR_WIDTH-1:0] hw_set,
  output logic [COUNT*MMR_WIDTH-1:0] val,
  output logic [COUNT-1:0]           wr_strobe,
  output logic [COUNT-1:0]           rd_strobe,
  output logic                       irq
);

  localparam logic [BUS_ADDR_WIDTH:0]   BASE_X  = (BUS_ADDR_WIDTH + 1)'(BASE);
  localparam logic [BUS_ADDR_WIDTH-1:0] COUNT_A = BUS_ADDR_WIDTH'(COUNT);

  logic [BUS_ADDR_WIDTH:0]     off_x;
  logic [BUS_ADDR_WIDTH-1:0]   off;
  logic                        hit;
  logic [COUNT-1:0]            wr_sel, rd_sel;
  logic                        rd_drive;
  logic [BUS_DATA_WIDTH-1:0]   rd_word;
  logic [COUNT*MMR_WIDTH-1:0]  w1c_bits;
  logic                        irq_q, irq_d;

  // The extra top bit of the subtraction is the borrow: it flags addresses below BASE,
  // so the offset never wraps back into the window.
  assign off_x = {1'b0, addr} - BASE_X;
  assign off   = off_x[BUS_ADDR_WIDTH-1:0];
  assign hit   = enable && !off_x[BUS_ADDR_WIDTH] && (off < COUNT_A);

  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    rd_drive = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (hit && (off == BUS_ADDR_WIDTH'(i))) begin
        wr_sel[i] = rw;
        rd_sel[i] = !rw;
        rd_drive  = !rw && RE_MASK[i];
        rd_word   = BUS_DATA_WIDTH'(val[i*MMR_WIDTH +: MMR_WIDTH]);
      end
    end
  end

  assign data = (rd_drive && reset_n) ? rd_word : 'z;

  for (genvar i = 0; i < COUNT; i++) begin : g_cell
    mmr_bank_cell #(
      .W         (MMR_WIDTH),
      .MODE      (mode_at((2*MMR_MAX_COUNT)'(MODES), i)),
      .RESET_VAL (DEFAULTS[i*MMR_WIDTH +: MMR_WIDTH])
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus_we    (wr_sel[i]),
      .bus_re    (rd_sel[i]),
      .bus_wdata (data[MMR_WIDTH-1:0]),
      .hw_we     (hw_we[i]),
      .hw_val    (hw_val[i*MMR_WIDTH +: MMR_WIDTH]),
      .hw_set    (hw_set[i*MMR_WIDTH +: MMR_WIDTH]),
      .val       (val[i*MMR_WIDTH +: MMR_WIDTH]),
      .w1c_bits  (w1c_bits[i*MMR_WIDTH +: MMR_WIDTH]),
      .wr_strobe (wr_strobe[i]),
      .rd_strobe (rd_strobe[i])
    );
  end

  assign irq_d = |w1c_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule
